v_rr_priority_arbiter: RTL and testbench
========================================

// Module: v_rr_priority_arbiter
// PURPOSE
//  Round-robin arbiter sharing one resource between NREQ requesters.
//  The selection core is a fixed-priority 1-of-N encoder that picks the lowest set index.
//  It runs on a request vector rotated by a registered priority pointer, so every requester is served fairly.
//  Grants are registered and held until the owner releases, drops its request, or overstays MAX_HOLD cycles.
//  Sits between requester sel-vectors and a shared datapath/bus mux, which is driven by gnt_code.
// PARAMETERS
//  NREQ      8   number of requesters (2..2**CW)
//  CW        3   width of gnt_code and priority pointer
//  MAX_HOLD  16  max consecutive cycles one grant may be held (>=1); counter width $clog2(MAX_HOLD+1)
// PORTS
//  clk        in   1     single clock; all state updates on rising edge
//  rst        in   1     synchronous, active-high reset
//  en         in   1     1 = new grants allowed; 0 = no new grant, a current grant runs to release
//  req        in   NREQ  request vector, bit i = requester i wants the resource (level)
//  done       in   1     release pulse from the current owner; ignored when gnt_valid=0
//  gnt        out  NREQ  registered one-hot grant; all-zero when no grant
//  gnt_code   out  CW    registered binary index of the owner; 0 when gnt_valid=0 (never X)
//  gnt_valid  out  1     registered; 1 while a grant is held
// BEHAVIOUR
//  Reset (rst=1 at an edge, any state): gnt=0, gnt_code=0, gnt_valid=0, ptr=0, hold_cnt=0, state=IDLE.
//   Reset overrides en/req/done, and a grant in progress is dropped.
//  Pick function: first index i at or after ptr with req[i]=1, searching ptr..NREQ-1 then 0..ptr-1 (wrap).
//   Implemented as rotate -> fixed-priority encode (lowest index wins) -> un-rotate (add ptr mod NREQ).
//  FSM has two states.
//   IDLE:
//    - If en=1 and |req, register the pick: gnt/gnt_code/gnt_valid take effect at the next edge
//      (latency 1 cycle from req sampled), hold_cnt=1, go to GRANT.
//    - Otherwise outputs stay 0.
//   GRANT: release condition rel = done | ~req[gnt_code] | (hold_cnt==MAX_HOLD).
//    - rel=0: outputs hold, hold_cnt increments (saturating, never wraps).
//    - rel=1: ptr <= (gnt_code+1) mod NREQ (wrap NREQ-1 -> 0).
//      The same edge re-picks from the current req with the NEW ptr, so the previous owner has lowest priority.
//      If en=1 and a pick exists, the new grant is registered back-to-back with no dead cycle and hold_cnt=1.
//      Otherwise all outputs clear and the FSM goes to IDLE.
//    - The former owner may be re-granted immediately only if it is the sole requester and still asserts req.
//  Simultaneous events:
//   - done together with a timeout counts as a single release.
//   - en falling during GRANT does not revoke the grant.
//   - req changes of non-owners during GRANT have no effect until release.
//  Invariants: gnt is one-hot or zero; gnt==(gnt_valid << gnt_code); ptr changes only on release.
//  Unused encoder code (no request) never reaches outputs; gnt_code is forced to 0 in that case.
// STRUCTURE
//  Shared include v_arbiter_defs.vh holds the state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1,
//   plus a clog2 constant function.
//  One sub-module, v_rr_pick (combinational): inputs req, ptr; outputs pick_code, pick_valid.
//   It contains the rotate, the fixed-priority encoder and the un-rotate.
//  The top level holds the FSM, ptr, hold_cnt and the output registers.
// TESTING
//  1 Reset: rst=1 with req=8'hFF -> gnt=0, gnt_valid=0 every cycle.
//    Then rst=0, req=8'h01 -> one edge later gnt=8'h01, gnt_code=0, gnt_valid=1.
//  2 Fair rotation: req=8'hFF, done pulsed each grant cycle -> gnt_code sequence 0,1,2,...,7,0.
//    Back-to-back, gnt_valid never drops.
//  3 Wrap: owner 5 releases (ptr=6), req=8'h09 -> next gnt_code=0, then after done gnt_code=3.
//  4 Timeout: MAX_HOLD=16, req=8'h06 constant, done=0 -> code 1 held exactly 16 cycles, then code 2 for 16, then 1.
//  5 Req drop and en: owner 4 deasserts req with no other request -> next edge all outputs 0, IDLE.
//    With en=0 and req=8'hFF -> no grant; en=1 -> grant to ptr=5.
//  6 Reset mid-grant: rst pulse while gnt_code=3 -> next edge outputs 0, ptr=0.
//    Then req=8'h88 -> gnt_code=3.

Source files
------------

// File: rtl/v_rr_priority_arbiter_pkg.sv
// v_rr_priority_arbiter_pkg: FSM state encodings and a constant clog2 shared by the arbiter files
package v_rr_priority_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/v_rr_priority_arbiter_pick.sv
// v_rr_pick: round-robin pick, done by rotating req by ptr, taking the lowest set index, then un-rotating
module v_rr_pick #(
    parameter int NREQ = 8,
    parameter int CW   = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic [CW-1:0]   pick_code,
    output logic            pick_valid
);

    logic [NREQ-1:0] rot;
    logic [CW-1:0]   enc;

    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        int s;
        s = int'(a) + int'(b);
        if (s >= NREQ) s -= NREQ;
        return s[CW-1:0];
    endfunction

    always_comb begin
        rot = '0;
        for (int i = 0; i < NREQ; i++) rot[i] = req[wrap_add(CW'(i), ptr)];
        enc = '0;
        for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) enc = CW'(i);
        pick_valid = |req;
        pick_code  = pick_valid ? wrap_add(enc, ptr) : '0;
    end

endmodule

// File: rtl/v_rr_priority_arbiter.sv
// v_rr_priority_arbiter: round-robin arbiter with registered grants, release on done/req drop/hold timeout
module v_rr_priority_arbiter
    import v_rr_priority_arbiter_pkg::*;
#(
    parameter int NREQ     = 8,
    parameter int CW       = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [CW-1:0]   gnt_code,
    output logic            gnt_valid
);

    localparam int HW = clog2(MAX_HOLD + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [CW-1:0]   code_q, code_d;
    logic            valid_q, valid_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]   pick_code;
    logic            pick_valid;
    logic            at_max, rel, take;

    // The picker sees the post-release pointer so the old owner ranks last on a back-to-back re-pick
    v_rr_pick #(.NREQ(NREQ), .CW(CW)) u_pick (
        .req       (req),
        .ptr       (ptr_d),
        .pick_code (pick_code),
        .pick_valid(pick_valid)
    );

    always_comb begin
        at_max  = hold_q == HW'(MAX_HOLD);
        rel     = done | ~req[code_q] | at_max;
        take    = (state_q == ST_IDLE) | rel;
        ptr_d   = (state_q == ST_GRANT && rel) ? ((code_q == CW'(NREQ - 1)) ? '0 : code_q + 1'b1) : ptr_q;
        state_d = state_q;
        hold_d  = at_max ? hold_q : hold_q + 1'b1;
        code_d  = code_q;
        valid_d = valid_q;
        gnt_d   = gnt_q;
        if (take) begin
            valid_d = en & pick_valid;
            state_d = valid_d ? ST_GRANT : ST_IDLE;
            code_d  = valid_d ? pick_code : '0;
            hold_d  = valid_d ? HW'(1) : '0;
            gnt_d   = valid_d ? ({{(NREQ-1){1'b0}}, 1'b1} << pick_code) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_code  = code_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_v_rr_priority_arbiter.sv
// tb_v_rr_priority_arbiter: directed vectors with hand-computed grants for the round-robin arbiter
module tb_v_rr_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [7:0] req = 8'hFF;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_code;
    logic       gnt_valid;
    int         n_cmp = 0;
    int         n_err = 0;

    v_rr_priority_arbiter #(.NREQ(8), .CW(3), .MAX_HOLD(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_code (gnt_code),
        .gnt_valid(gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic valid, input logic [2:0] code);
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(valid));
        chk({tag, ".code"}, 32'(gnt_code), valid ? 32'(code) : 32'd0);
        chk({tag, ".gnt"}, 32'(gnt), valid ? (32'd1 << code) : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] seq [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        // reset holds everything clear even with all requests pending
        for (int i = 0; i < 3; i++) begin
            step();
            chk_gnt("reset", 1'b0, 3'd0);
        end
        rst = 1'b0;
        req = 8'h01;
        step();
        chk_gnt("first_grant", 1'b1, 3'd0);
        // fair rotation with done every cycle
        req = 8'hFF;
        done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_gnt($sformatf("rotate%0d", i), 1'b1, seq[i]);
        end
        // wrap: owner 5 releases, ptr=6, req 09 -> 0 then 3
        done = 1'b0;
        req = 8'h20;
        step();
        chk_gnt("own5", 1'b1, 3'd5);
        req = 8'h09;
        done = 1'b1;
        step();
        chk_gnt("wrap0", 1'b1, 3'd0);
        step();
        chk_gnt("wrap3", 1'b1, 3'd3);
        // timeout: 16 cycles of 1, 16 of 2, then back to 1
        done = 1'b0;
        req = 8'h06;
        step();
        chk_gnt("to_start", 1'b1, 3'd1);
        for (int i = 1; i < 16; i++) begin
            step();
            chk($sformatf("to_hold1_%0d", i), 32'(gnt_code), 32'd1);
        end
        step();
        chk_gnt("to_sw2", 1'b1, 3'd2);
        for (int i = 1; i < 16; i++) begin
            step();
            chk($sformatf("to_hold2_%0d", i), 32'(gnt_code), 32'd2);
        end
        step();
        chk_gnt("to_sw1", 1'b1, 3'd1);
        // req drop with no other requester goes idle
        req = 8'h10;
        step();
        chk_gnt("own4", 1'b1, 3'd4);
        req = 8'h00;
        step();
        chk_gnt("drop_idle", 1'b0, 3'd0);
        en = 1'b0;
        req = 8'hFF;
        step();
        chk_gnt("en_off0", 1'b0, 3'd0);
        step();
        chk_gnt("en_off1", 1'b0, 3'd0);
        en = 1'b1;
        step();
        chk_gnt("en_on", 1'b1, 3'd5);
        // en falling mid-grant keeps the grant; release then goes idle
        en = 1'b0;
        step();
        chk_gnt("en_fall_hold", 1'b1, 3'd5);
        done = 1'b1;
        step();
        chk_gnt("en_off_release", 1'b0, 3'd0);
        // reset mid-grant clears ptr: 88 picks 3 from ptr 0 (ptr 6 would give 7)
        done = 1'b0;
        en = 1'b1;
        req = 8'h08;
        step();
        chk_gnt("own3", 1'b1, 3'd3);
        rst = 1'b1;
        step();
        chk_gnt("mid_reset", 1'b0, 3'd0);
        rst = 1'b0;
        req = 8'h88;
        step();
        chk_gnt("post_reset", 1'b1, 3'd3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
